// File: rtl/biriscv_mul_wb_tracker.sv
// Tag sidecar for the pipelined multiplier: tracks {valid, rd, pc} per stage, forms the
// writeback beat and raises RAW stalls. Optional final-stage forwarding via MUL_WB_FWD_EN.
module biriscv_mul_wb_tracker #(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_ra_idx_i,
    input  logic [4:0]  opcode_rb_idx_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] mul_value_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_value_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic        fwd_ra_valid_o,
    output logic        fwd_rb_valid_o,
    output logic [31:0] fwd_value_o
);
    localparam int N = MULT_STAGES;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] pc;
    } tag_t;

    tag_t [N-1:0] stg_q, stg_d;

    logic mul_w;
    logic issue;
    logic ra_nz, rb_nz;
    logic ra_pend, rb_pend;
    logic ra_last, rb_last;

    // Register index fields are taken from the dedicated ports, not the opcode word.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^{opcode_opcode_i[24:15], opcode_opcode_i[11:7]};

    assign mul_w = (opcode_opcode_i[6:0] == 7'b0110011) &&
                   (opcode_opcode_i[31:25] == 7'b0000001) &&
                   !opcode_opcode_i[14];

    assign issue = opcode_valid_i && mul_w && !flush_i && !stall_o;

    assign wb_valid_o  = stg_q[N-1].valid && (stg_q[N-1].rd != 5'd0);
    assign wb_rd_idx_o = stg_q[N-1].rd;
    assign wb_pc_o     = stg_q[N-1].pc;
    assign wb_value_o  = wb_valid_o ? mul_value_i : 32'b0;

    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < N; k++)
            busy_o = busy_o | stg_q[k].valid;
    end

    // Matches against the not-yet-final stages; the final stage is handled separately
    // because it may be forwarded instead of stalled on.
    always_comb begin
        ra_pend = 1'b0;
        rb_pend = 1'b0;
        for (int k = 0; k < N-1; k++) begin
            if (stg_q[k].valid && (stg_q[k].rd != 5'd0)) begin
                if (stg_q[k].rd == opcode_ra_idx_i) ra_pend = 1'b1;
                if (stg_q[k].rd == opcode_rb_idx_i) rb_pend = 1'b1;
            end
        end
    end

    assign ra_nz   = (opcode_ra_idx_i != 5'd0);
    assign rb_nz   = (opcode_rb_idx_i != 5'd0);
    assign ra_last = wb_valid_o && (stg_q[N-1].rd == opcode_ra_idx_i);
    assign rb_last = wb_valid_o && (stg_q[N-1].rd == opcode_rb_idx_i);

`ifdef MUL_WB_FWD_EN
    assign stall_o        = opcode_valid_i && ((ra_nz && ra_pend) || (rb_nz && rb_pend));
    // A younger pending write to the same register shadows the final-stage value.
    assign fwd_ra_valid_o = opcode_valid_i && ra_nz && ra_last && !ra_pend;
    assign fwd_rb_valid_o = opcode_valid_i && rb_nz && rb_last && !rb_pend;
    assign fwd_value_o    = (fwd_ra_valid_o || fwd_rb_valid_o) ? mul_value_i : 32'b0;
`else
    assign stall_o        = opcode_valid_i && ((ra_nz && (ra_pend || ra_last)) ||
                                               (rb_nz && (rb_pend || rb_last)));
    assign fwd_ra_valid_o = 1'b0;
    assign fwd_rb_valid_o = 1'b0;
    assign fwd_value_o    = 32'b0;
`endif

    always_comb begin
        stg_d = stg_q;
        if (flush_i && hold_i) begin
            for (int k = 0; k < N-1; k++)
                stg_d[k].valid = 1'b0;
        end else if (!hold_i) begin
            stg_d[0].valid = issue;
            stg_d[0].rd    = opcode_rd_idx_i;
            stg_d[0].pc    = opcode_pc_i;
            for (int k = 1; k < N; k++)
                stg_d[k] = stg_q[k-1];
            // The tag entering the final stage is committed; only younger ones die.
            if (flush_i) begin
                for (int k = 0; k < N-1; k++)
                    stg_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stg_q <= '0;
        else        stg_q <= stg_d;
    end
endmodule

// File: tb/tb_biriscv_mul_wb_tracker.sv
// Random-stimulus bench for biriscv_mul_wb_tracker at MULT_STAGES=2 and 3, checked against
// an age-ordered list model of in-flight multiplies.
module tb_biriscv_mul_wb_tracker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        opv;
    logic [31:0] opc, pc;
    logic [4:0]  rd, ra, rb;
    logic        hold, flush;
    logic [31:0] mulv;

    logic [1:0]  wbv, stall, busy, fra, frb;
    logic [4:0]  wbrd [2];
    logic [31:0] wbpc [2];
    logic [31:0] wbval[2];
    logic [31:0] fval [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        int          age;
        logic [4:0]  rd;
        logic [31:0] pc;
    } op_t;
    op_t q[$];

    always #5 clk = ~clk;

    biriscv_mul_wb_tracker #(.MULT_STAGES(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .opcode_valid_i(opv), .opcode_opcode_i(opc),
        .opcode_pc_i(pc), .opcode_rd_idx_i(rd), .opcode_ra_idx_i(ra), .opcode_rb_idx_i(rb),
        .hold_i(hold), .flush_i(flush), .mul_value_i(mulv),
        .wb_valid_o(wbv[0]), .wb_rd_idx_o(wbrd[0]), .wb_pc_o(wbpc[0]), .wb_value_o(wbval[0]),
        .stall_o(stall[0]), .busy_o(busy[0]), .fwd_ra_valid_o(fra[0]), .fwd_rb_valid_o(frb[0]),
        .fwd_value_o(fval[0]));

    biriscv_mul_wb_tracker #(.MULT_STAGES(3)) u_n3 (
        .clk(clk), .rst_n(rst_n), .opcode_valid_i(opv), .opcode_opcode_i(opc),
        .opcode_pc_i(pc), .opcode_rd_idx_i(rd), .opcode_ra_idx_i(ra), .opcode_rb_idx_i(rb),
        .hold_i(hold), .flush_i(flush), .mul_value_i(mulv),
        .wb_valid_o(wbv[1]), .wb_rd_idx_o(wbrd[1]), .wb_pc_o(wbpc[1]), .wb_value_o(wbval[1]),
        .stall_o(stall[1]), .busy_o(busy[1]), .fwd_ra_valid_o(fra[1]), .fwd_rb_valid_o(frb[1]),
        .fwd_value_o(fval[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Does source r depend on an in-flight op of model m that must stall?
    function automatic bit hazard(int m, logic [4:0] r);
        int n = m + 2;
        bit h = 0;
        if (r == 5'd0) return 0;
        foreach (q[i])
            if (q[i].m == m && q[i].rd == r) begin
`ifdef MUL_WB_FWD_EN
                if (q[i].age < n) h = 1;
`else
                h = 1;
`endif
            end
        return h;
    endfunction

    // Final-stage match for source r that is not shadowed by a younger write.
    function automatic bit fwd_hit(int m, logic [4:0] r);
        int n = m + 2;
        bit last = 0;
        bit young = 0;
        if (r == 5'd0) return 0;
        foreach (q[i])
            if (q[i].m == m && q[i].rd == r) begin
                if (q[i].age == n) last = 1;
                else               young = 1;
            end
        return last && !young;
    endfunction

    task automatic step_model(input int m, input bit iss);
        int n = m + 2;
        op_t nq[$];
        foreach (q[i]) begin
            op_t e = q[i];
            if (e.m != m) begin
                nq.push_back(e);
            end else if (!rst_n) begin
                // dropped
            end else if (flush && hold) begin
                if (e.age == n) nq.push_back(e);
            end else if (hold) begin
                nq.push_back(e);
            end else if (e.age < n) begin
                e.age++;
                if (!flush || e.age == n) nq.push_back(e);
            end
        end
        if (rst_n && !hold && iss) begin
            op_t e;
            e.m = m; e.age = 1; e.rd = rd; e.pc = pc;
            nq.push_back(e);
        end
        q = nq;
    endtask

    task automatic check_cycle(input bit is_mul);
        bit iss [2];
        for (int m = 0; m < 2; m++) begin
            int n = m + 2;
            bit ev = 0;
            bit eb = 0;
            bit es;
            bit efa = 0;
            bit efb = 0;
            logic [4:0]  erd = '0;
            logic [31:0] epc = '0;
            string s = (m == 0) ? "n2" : "n3";
            foreach (q[i])
                if (q[i].m == m) begin
                    eb = 1;
                    if (q[i].age == n && q[i].rd != 5'd0) begin
                        ev = 1; erd = q[i].rd; epc = q[i].pc;
                    end
                end
            es = opv && (hazard(m, ra) || hazard(m, rb));
`ifdef MUL_WB_FWD_EN
            efa = opv && fwd_hit(m, ra) && !hazard(m, ra);
            efb = opv && fwd_hit(m, rb) && !hazard(m, rb);
`endif
            chk({s, "_wb_valid"}, 32'(wbv[m]), 32'(ev));
            if (ev) begin
                chk({s, "_wb_rd"}, 32'(wbrd[m]), 32'(erd));
                chk({s, "_wb_pc"}, wbpc[m], epc);
            end
            chk({s, "_wb_value"}, wbval[m], ev ? mulv : 32'b0);
            chk({s, "_stall"}, 32'(stall[m]), 32'(es));
            chk({s, "_busy"}, 32'(busy[m]), 32'(eb));
            chk({s, "_fwd_ra"}, 32'(fra[m]), 32'(efa));
            chk({s, "_fwd_rb"}, 32'(frb[m]), 32'(efb));
            chk({s, "_fwd_value"}, fval[m], (efa || efb) ? mulv : 32'b0);
            iss[m] = opv && is_mul && !flush && !es;
        end
        for (int m = 0; m < 2; m++) step_model(m, iss[m]);
    endtask

    initial begin
        bit      is_mul;
        int      kind;
        rst_n = 1'b0; opv = 1'b0; opc = '0; pc = '0; rd = '0; ra = '0; rb = '0;
        hold = 1'b0; flush = 1'b0; mulv = '0;
        repeat (2) @(posedge clk);

        // Reset state, with hold/flush asserted to show reset dominates.
        @(negedge clk);
        hold = 1'b1; flush = 1'b1;
        #1 check_cycle(1'b0);
        hold = 1'b0; flush = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            opv   = ($urandom_range(0, 9) < 8);
            hold  = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 99) < 8);
            rd    = 5'($urandom_range(0, 7));
            ra    = 5'($urandom_range(0, 7));
            rb    = 5'($urandom_range(0, 7));
            pc    = $urandom;
            mulv  = $urandom;
            kind  = $urandom_range(0, 9);
            is_mul = (kind < 7);
            case (kind)
                7:       opc = {7'b0000000, rb, ra, 3'($urandom_range(0, 7)), rd, 7'b0110011};
                8:       opc = {7'b0000001, rb, ra, 3'($urandom_range(4, 7)), rd, 7'b0110011};
                9:       opc = {7'b0000001, rb, ra, 3'($urandom_range(0, 3)), rd, 7'b0010011};
                default: opc = {7'b0000001, rb, ra, 3'($urandom_range(0, 3)), rd, 7'b0110011};
            endcase
            #1 check_cycle(is_mul);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
